// File: rtl/demux_scan_pkg.sv
// Shared constants, FSM state type and a set-bit search helper for demux_scan_ctrl.
package demux_scan_pkg;

  localparam int CHANNELS = 16;
  localparam int SEL_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    FIN     = 2'd2,
    SKIPCHK = 2'd3
  } state_t;

  // Lowest set bit of word at or above index from; MSB of the result flags "none found".
  function automatic logic [SEL_W:0] find_set_from(input logic [CHANNELS-1:0] word,
                                                   input logic [SEL_W:0]      from);
    logic [SEL_W:0] res;
    res = {1'b1, {SEL_W{1'b0}}};
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (word[i] && ((SEL_W + 1)'(i) >= from)) begin
        res = {1'b0, SEL_W'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/demux_scan_ctrl_prescaler.sv
// Dwell prescaler: counts 0..limit while enabled and flags the terminal count.
module scan_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] limit,
  output logic [DIV_W-1:0] count,
  output logic             tc
);

  // Comparing against the limit means an all-ones limit never wraps the counter.
  assign tc = en && (count == limit);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr || tc) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Scan sequencer feeding a 16-way demux: walks the latched word one channel per dwell.
// Optional macro DEMUX_SCAN_SKIP_EN: present only channels whose latched bit is 1.
module demux_scan_ctrl #(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4,
  parameter int DIV_W    = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic [CHANNELS-1:0] Data,
  input  logic [DIV_W-1:0]    Div,
  output logic [SEL_W-1:0]    Choice,
  output logic                Bit,
  output logic                Valid,
  output logic                Busy,
  output logic                Done
);

  import demux_scan_pkg::*;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  state_t              state, state_n;
  logic [CHANNELS-1:0] word;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    dwell_cnt;
  logic [SEL_W-1:0]    chan, chan_n;
  logic [SEL_W-1:0]    choice_n;
  logic                bit_n, valid_n, busy_n, done_n;
  logic                load, tc;
`ifdef DEMUX_SCAN_SKIP_EN
  logic [SEL_W:0]      first, nxt;
`endif

  scan_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk     (Clk),
    .reset_n (Reset_n),
    .clr     (load),
    .en      (state == SCAN),
    .limit   (div_q),
    .count   (dwell_cnt),
    .tc      (tc)
  );

  // Next-state logic also computes the next output values so every output leaves a flop.
  always_comb begin
    state_n  = state;
    chan_n   = chan;
    load     = 1'b0;
    choice_n = '0;
    bit_n    = 1'b0;
    valid_n  = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
`ifdef DEMUX_SCAN_SKIP_EN
    first = find_set_from(Data, '0);
    nxt   = find_set_from(word, {1'b0, chan} + 1'b1);
`endif
    case (state)
      IDLE, FIN: begin
        state_n = IDLE;
        if (Start) begin
          load   = 1'b1;
          busy_n = 1'b1;
`ifdef DEMUX_SCAN_SKIP_EN
          if (first[SEL_W]) begin
            state_n = SKIPCHK;
          end else begin
            state_n  = SCAN;
            chan_n   = first[SEL_W-1:0];
            choice_n = chan_n;
            bit_n    = 1'b1;
            valid_n  = 1'b1;
          end
`else
          state_n  = SCAN;
          chan_n   = '0;
          choice_n = '0;
          bit_n    = Data[0];
          valid_n  = 1'b1;
`endif
        end
      end
      SCAN: begin
        if (!tc) begin
          choice_n = chan;
          bit_n    = word[chan];
          valid_n  = 1'b1;
          busy_n   = 1'b1;
        end else begin
`ifdef DEMUX_SCAN_SKIP_EN
          if (nxt[SEL_W]) begin
            state_n = FIN;
            done_n  = 1'b1;
          end else begin
            chan_n   = nxt[SEL_W-1:0];
            choice_n = chan_n;
            bit_n    = 1'b1;
            valid_n  = 1'b1;
            busy_n   = 1'b1;
          end
`else
          if (chan == LAST_CH) begin
            state_n = FIN;
            done_n  = 1'b1;
          end else begin
            chan_n   = chan + 1'b1;
            choice_n = chan_n;
            bit_n    = word[chan_n];
            valid_n  = 1'b1;
            busy_n   = 1'b1;
          end
`endif
        end
      end
      SKIPCHK: begin
        state_n = FIN;
        done_n  = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state  <= IDLE;
      chan   <= '0;
      word   <= '0;
      div_q  <= '0;
      Choice <= '0;
      Bit    <= 1'b0;
      Valid  <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      state  <= state_n;
      chan   <= chan_n;
      Choice <= choice_n;
      Bit    <= bit_n;
      Valid  <= valid_n;
      Busy   <= busy_n;
      Done   <= done_n;
      if (load) begin
        word  <= Data;
        div_q <= Div;
      end
    end
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed self-checking bench for demux_scan_ctrl (default build and DEMUX_SCAN_SKIP_EN build).
module tb_demux_scan_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [15:0] Data;
  logic [7:0]  Div;
  logic [3:0]  Choice;
  logic        Bit;
  logic        Valid;
  logic        Busy;
  logic        Done;

  int compared   = 0;
  int mismatched = 0;

  demux_scan_ctrl dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .Data    (Data),
    .Div     (Div),
    .Choice  (Choice),
    .Bit     (Bit),
    .Valid   (Valid),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_n, input logic start,
                               input logic [15:0] data, input logic [7:0] div);
    Reset_n = rst_n;
    Start   = start;
    Data    = data;
    Div     = div;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Packs outputs as {Choice, Bit, Valid, Busy, Done}.
  task automatic expectOutputs(input string tag, input logic [3:0] ch, input logic b,
                               input logic v, input logic bz, input logic d);
    checkOutput(tag, {24'd0, Choice, Bit, Valid, Busy, Done}, {24'd0, ch, b, v, bz, d});
  endtask

  initial begin
    logic [15:0] patA;
    int validCount;
    int ch0Count;
    int bitErr;
    int budget;

    applyStimulus(1'b0, 1'b0, 16'h0000, 8'd0);
    tick();
    tick();
    expectOutputs("reset_state", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    tick();
    expectOutputs("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifndef DEMUX_SCAN_SKIP_EN
    // Frame A: 16'hA5A5, Div=0, one channel per cycle.
    patA = 16'hA5A5;
    applyStimulus(1'b1, 1'b1, patA, 8'd0);
    tick();
    Start = 1'b0;
    Data  = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      expectOutputs($sformatf("A_ch%0d", i), 4'(i), patA[i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    expectOutputs("A_done", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expectOutputs("A_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame B: 16'h8001, Div=3, with an ignored mid-frame Start carrying 16'hFFFF.
    applyStimulus(1'b1, 1'b1, 16'h8001, 8'd3);
    tick();
    Start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      expectOutputs($sformatf("B_cyc%0d", i), 4'(i / 4), ((i / 4) == 0) || ((i / 4) == 15),
                    1'b1, 1'b1, 1'b0);
      if (i == 20) applyStimulus(1'b1, 1'b1, 16'hFFFF, 8'd0);
      if (i == 21) Start = 1'b0;
      tick();
    end
    applyStimulus(1'b1, 1'b1, 16'h0003, 8'd0);
    expectOutputs("B_done", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    Start = 1'b0;
    expectOutputs("C_backtoback_ch0", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    for (int ch = 1; ch <= 7; ch++) begin
      expectOutputs($sformatf("C_ch%0d", ch), 4'(ch), (ch < 2), 1'b1, 1'b1, 1'b0);
      if (ch < 7) tick();
    end
    Reset_n = 1'b0;
    tick();
    expectOutputs("C_abort_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expectOutputs($sformatf("C_idle%0d", i), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Frame D: Div=8'hFF, 16'h0001 -> 256-cycle dwell, 4096 valid cycles.
    applyStimulus(1'b1, 1'b1, 16'h0001, 8'hFF);
    tick();
    Start      = 1'b0;
    validCount = 0;
    ch0Count   = 0;
    bitErr     = 0;
    budget     = 5000;
    while (!Done && budget > 0) begin
      if (Valid) validCount++;
      if (Valid && Choice == 4'd0) ch0Count++;
      if (Valid && (Bit !== (Choice == 4'd0))) bitErr++;
      tick();
      budget--;
    end
    checkOutput("D_valid_len", validCount, 32'd4096);
    checkOutput("D_ch0_dwell", ch0Count, 32'd256);
    checkOutput("D_bit_errs", bitErr, 32'd0);
    expectOutputs("D_done", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expectOutputs("D_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    // Skip build: 16'h0104 presents channels 2 and 8 only, two cycles each.
    applyStimulus(1'b1, 1'b1, 16'h0104, 8'd1);
    tick();
    Start = 1'b0;
    expectOutputs("S_ch2_a", 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    expectOutputs("S_ch2_b", 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    expectOutputs("S_ch8_a", 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    expectOutputs("S_ch8_b", 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    expectOutputs("S_done", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expectOutputs("S_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Empty word: busy for one cycle, then Done, never Valid.
    applyStimulus(1'b1, 1'b1, 16'h0000, 8'd1);
    tick();
    Start = 1'b0;
    expectOutputs("Z_busy", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expectOutputs("Z_done", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expectOutputs("Z_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/demux_scan_ctrl.md
Name: demux_scan_ctrl

Overview:
- Upstream sequencer for the 16-way demultiplexer: drives its 1-bit data input and 4-bit channel select.
- Latches a 16-bit parallel word on a Start handshake, then walks channels 0..15 in order.
- For each channel it presents the channel index on Choice and the matching word bit on Bit, holding each channel for a programmable dwell time.
- Signals Busy during the scan and pulses Done when the frame completes.

Parameters:
- CHANNELS, 16, number of channels scanned per frame; must equal 2**SEL_W.
- SEL_W, 4, width of Choice.
- DIV_W, 8, width of the dwell-divider input Div.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  synchronous, active-low reset, sampled on rising Clk.
- Start  input  1  frame request; accepted only in IDLE.
- Data  input  CHANNELS  parallel word; bit i is sent on channel i.
- Div  input  DIV_W  dwell per channel = Div+1 clock cycles.
- Choice  output  SEL_W  channel select to the demux.
- Bit  output  1  serial data to the demux input.
- Valid  output  1  high while Choice/Bit carry a frame channel.
- Busy  output  1  high from Start acceptance until the frame ends.
- Done  output  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (Reset_n=0 at an edge): state IDLE, Choice=0, Bit=0, Valid=0, Busy=0, Done=0; divider, channel counter and data latch cleared.
- Reset mid-frame aborts the frame at the next edge. No Done is issued.
- FSM states:
  - IDLE: waiting for Start.
  - SCAN: presenting a channel.
  - FIN: one cycle, Done=1.
- IDLE -> SCAN: Start=1 at edge k.
  - Data and Div are latched at that edge; later changes are ignored for the frame.
  - At cycle k+1: Choice=0, Bit=Data[0], Valid=1, Busy=1.
- In SCAN:
  - The dwell counter counts 0..Div_latched.
  - On the terminal count with channel < CHANNELS-1: channel increments, Choice=channel+1 and Bit=word[channel+1] on the next cycle, and the dwell counter resets to 0.
  - On the terminal count with channel = CHANNELS-1: go to FIN.
- FIN: Valid=0, Busy=0, Bit=0, Choice=0, Done=1 for exactly one cycle, then IDLE.
- Start is ignored in SCAN.
- Start in FIN is accepted, so back-to-back frames have one idle cycle between them.
- Frame length: Valid high for exactly CHANNELS*(Div+1) cycles.
- Div=0: one cycle per channel (16 cycles per frame).
- Div=all-ones: 256 cycles per channel; the dwell counter does not overflow (compare is to Div_latched, counter is DIV_W bits).
- Choice and Bit change only at dwell boundaries and never glitch within a dwell; all outputs are registered.
- Outside SCAN, Choice=0 and Bit=0, so the demux outputs are all low.

Optional Feature:
- Macro DEMUX_SCAN_SKIP_EN.
- Defined:
  - Channels whose latched bit is 0 are skipped with no dwell; only 1-bits are presented.
  - The next channel is the lowest set bit above the current one, found combinationally.
  - Frame Valid time = popcount(Data)*(Div+1).
  - Data=0: SCAN is bypassed. Start at edge k gives Busy=1 and Valid=0 at k+1 and Done at k+2.
- Undefined: all 16 channels are always visited, as described above.

Decomposition:
- Package demux_scan_pkg holds:
  - CHANNELS and SEL_W constants.
  - State enum: IDLE, SCAN, FIN (plus SKIPCHK if needed under the macro).
- One sub-module, scan_prescaler:
  - DIV_W-bit dwell counter with synchronous clear and a terminal-count output.
  - Reused by later display-scan blocks.

Test Plan:
- Reset then Start with Data=16'hA5A5, Div=0 -> Valid for 16 cycles; Choice 0..15 one per cycle; Bit sequence 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1; Done one cycle after the last channel.
- Div=3, Data=16'h8001 -> each Choice held 4 cycles; Bit=1 only on Choice 0 and 15; Busy high 64 cycles, then Done.
- Start re-pulsed mid-frame with Data changed to 16'hFFFF -> ignored; the original word completes. Start asserted in the FIN cycle -> a new frame begins on the next cycle.
- Reset_n=0 while on Choice=7 -> next edge: all outputs 0 and no Done; after release, the FSM is idle until Start.
- Div=8'hFF, Data=16'h0001 -> Choice=0 held 256 cycles, total Valid 4096 cycles.
- SKIP_EN build, Data=16'h0104, Div=1 -> Choice=2 for 2 cycles, then Choice=8 for 2 cycles, then Done. Data=0 -> Done 2 cycles after Start and Valid never high.
